// File: rtl/spi_slave_control.sv
// rtl/spi_slave_control.sv - SPI mode-0 slave: oversampled receive, word assembly and MISO response (option: SPI_SLAVE_ECHO_EN)
module spi_slave_control #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic sclk_d, ss_d;
    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-2:0] rx_sh;
    logic [DATA_W-1:0] shift_in;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] frame_load;
    logic [DATA_W-1:0] word_load;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    // Full word as it would look after shifting in the current mosi sample;
    // rx_sh only keeps the DATA_W-1 bits that still have to move up.
    assign shift_in = {rx_sh, mosi_s};

    // Bits leave MSB first, so the bit index counts down as bit_cnt counts up.
    assign bit_idx = LAST_BIT - bit_cnt;

`ifdef SPI_SLAVE_ECHO_EN
    // Loopback: the response is the most recently completed word.
    assign frame_load = rx_data;
    assign word_load  = shift_in;
`else
    assign frame_load = tx_data;
    assign word_load  = tx_data;
`endif

    // Synchronise the SPI pins and keep one extra flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame boundaries follow the synchronised slave select.
    always_comb begin
        next_state = state;
        if (state == IDLE) begin
            if (ss_fall) begin
                next_state = ACTIVE;
            end
        end else begin
            if (ss_rise) begin
                next_state = IDLE;
            end
        end
    end

    // Busy reflects an open frame.
    always_comb begin
        busy = 1'b0;
        if (state == ACTIVE) begin
            busy = 1'b1;
        end
    end

    // Shift/receive datapath; slave-select edges take priority over sclk edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg    <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            miso      <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_reg  <= frame_load;
                    bit_cnt <= '0;
                    miso    <= frame_load[DATA_W-1];
                end
            end else begin
                if (ss_rise) begin
                    miso <= 1'b1;
                    if (bit_cnt != '0) begin
                        frame_err <= 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_sh <= shift_in[DATA_W-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        rx_data  <= shift_in;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        tx_reg   <= word_load;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else if (sclk_fall) begin
                    miso <= tx_reg[bit_idx];
                end
            end
        end
    end

endmodule
